// File: rtl/semaforo_pkg.sv
// Shared definitions for the crossing traffic-light controller and its
// pedestrian push-button front end.
package semaforo_pkg;

    // Debounce defaults, also used by the light controller's top level
    localparam int DEB_CYCLES_DEF = 16;
    localparam int CNT_W_DEF      = 5;

    // Debounce FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_CHK_ON  = 2'b01;
    localparam logic [1:0] ST_HELD    = 2'b10;
    localparam logic [1:0] ST_CHK_OFF = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CHK_ON  = ST_CHK_ON,
        HELD    = ST_HELD,
        CHK_OFF = ST_CHK_OFF
    } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser bringing an asynchronous level into the CLK domain.
module sincronizador (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic s1;

    // Shift the raw level through two flops; only Q is safe to use
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1 <= 1'b0;
            Q  <= 1'b0;
        end else begin
            s1 <= D;
            Q  <= s1;
        end
    end

endmodule

// File: rtl/pulsador_peaton.sv
// Pedestrian push-button front end: synchronises and debounces the button
// and holds a request level T until the light controller acknowledges it.
module pulsador_peaton
    import semaforo_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic BTN,
    input  logic ACK,
    output logic T,
    output logic PRESS,
    output logic BUSY
);

    // The counter exits on this value, so it never wraps
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             btn_s;
    estado_t          state;
    estado_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;

    sincronizador u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (BTN),
        .Q   (btn_s)
    );

    // State register and debounce counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; every state change clears the counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        if (!EN) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state_nxt = CHK_ON;
                        cnt_nxt   = '0;
                    end
                end
                CHK_ON: begin
                    if (!btn_s) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_nxt = CHK_OFF;
                        cnt_nxt   = '0;
                    end
                end
                CHK_OFF: begin
                    if (btn_s) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Registered outputs, aligned with the state they describe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PRESS <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            PRESS <= press_nxt;
            BUSY  <= (state_nxt != IDLE);
        end
    end

    // Request latch: acknowledge wins over a coincident press
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            T <= 1'b0;
        end else if (ACK) begin
            T <= 1'b0;
        end else if (PRESS && EN) begin
            T <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pulsador_peaton.sv
// Bench for pulsador_peaton: directed scenarios with literal expectations
// followed by randomised stimulus, all compared every cycle against a
// run-length model of the debounced button.
module tb_pulsador_peaton;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic CLK;
    logic RST;
    logic EN;
    logic BTN;
    logic ACK;
    logic T;
    logic PRESS;
    logic BUSY;

    int checks;
    int errors;
    bit modelCheckOn;

    pulsador_peaton #(
        .DEB_CYCLES (DEB),
        .CNT_W      (CW)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .BTN   (BTN),
        .ACK   (ACK),
        .T     (T),
        .PRESS (PRESS),
        .BUSY  (BUSY)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: the accepted level flips once the synchronised
    // button has disagreed with it for DEB+1 consecutive samples
    logic mS1;
    logic mBs;
    logic mLvl;
    logic mPress;
    logic mT;
    int   mRun;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mS1    <= 1'b0;
            mBs    <= 1'b0;
            mLvl   <= 1'b0;
            mPress <= 1'b0;
            mT     <= 1'b0;
            mRun   <= 0;
        end else begin
            mS1    <= BTN;
            mBs    <= mS1;
            mT     <= ACK ? 1'b0 : ((mPress && EN) ? 1'b1 : mT);
            mPress <= 1'b0;
            if (!EN) begin
                mLvl <= 1'b0;
                mRun <= 0;
            end else if (mBs == mLvl) begin
                mRun <= 0;
            end else if (mRun + 1 == DEB + 1) begin
                mLvl   <= mBs;
                mRun   <= 0;
                mPress <= mBs;
            end else begin
                mRun <= mRun + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic en, input logic ack);
        BTN = btn;
        EN  = en;
        ACK = ack;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Every cycle out of reset, the outputs must match the model
    always @(negedge CLK) begin
        if (RST && modelCheckOn) begin
            checkOutput("model_T", T, mT);
            checkOutput("model_PRESS", PRESS, mPress);
            checkOutput("model_BUSY", BUSY, mLvl || (mRun != 0));
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        modelCheckOn = 1'b1;
        RST          = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("reset_T", T, 1'b0);
        checkOutput("reset_PRESS", PRESS, 1'b0);
        checkOutput("reset_BUSY", BUSY, 1'b0);
        waitNeg(3);
        checkOutput("reset_hold_BUSY", BUSY, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        waitNeg(4);

        $display("[TB] clean press");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(6);
        checkOutput("clean_press_early", PRESS, 1'b0);
        checkOutput("clean_busy_chk", BUSY, 1'b1);
        waitNeg(1);
        checkOutput("clean_press_at7", PRESS, 1'b1);
        checkOutput("clean_T_before", T, 1'b0);
        waitNeg(1);
        checkOutput("clean_press_single", PRESS, 1'b0);
        checkOutput("clean_T_at8", T, 1'b1);
        waitNeg(12);
        checkOutput("clean_T_stays", T, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(6);
        checkOutput("release_busy_at6", BUSY, 1'b1);
        waitNeg(1);
        checkOutput("release_busy_at7", BUSY, 1'b0);

        $display("[TB] handshake");
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitNeg(1);
        checkOutput("ack_clears_T", T, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(7);
        checkOutput("second_press", PRESS, 1'b1);
        checkOutput("second_T_before", T, 1'b0);
        waitNeg(1);
        checkOutput("second_T_at8", T, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(10);

        $display("[TB] bounce rejection");
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitNeg(1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(((i % 2) == 0), 1'b1, 1'b0);
            waitNeg(2);
            checkOutput("bounce_PRESS", PRESS, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(10);
        checkOutput("bounce_T", T, 1'b0);
        checkOutput("bounce_BUSY", BUSY, 1'b0);

        $display("[TB] simultaneous press and ack");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(7);
        checkOutput("coinc_PRESS", PRESS, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitNeg(1);
        checkOutput("coinc_T_dropped", T, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(2);
        checkOutput("coinc_T_still0", T, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(8);
        checkOutput("set_T_again", T, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(7);
        checkOutput("absorbed_PRESS", PRESS, 1'b1);
        waitNeg(1);
        checkOutput("absorbed_T", T, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(10);

        $display("[TB] enable and reset");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(1);
        checkOutput("ack_while_disabled", T, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(20);
        checkOutput("disabled_BUSY", BUSY, 1'b0);
        checkOutput("disabled_T", T, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitNeg(10);
        checkOutput("held_T", T, 1'b1);
        checkOutput("held_BUSY", BUSY, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async_rst_T", T, 1'b0);
        checkOutput("async_rst_PRESS", PRESS, 1'b0);
        checkOutput("async_rst_BUSY", BUSY, 1'b0);
        waitNeg(2);
        RST = 1'b1;
        waitNeg(6);
        checkOutput("rst_redebounce_early", PRESS, 1'b0);
        waitNeg(1);
        checkOutput("rst_redebounce_PRESS", PRESS, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(10);

        $display("[TB] randomised stimulus");
        for (int seg = 0; seg < 400; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(1, 0));
            len = $urandom_range(12, 1);
            for (int c = 0; c < len; c++) begin
                applyStimulus(lvl, ($urandom_range(19, 0) != 0), ($urandom_range(9, 0) == 0));
                if ($urandom_range(499, 0) == 0) begin
                    #2;
                    RST = 1'b0;
                    #1;
                    checkOutput("rand_rst_T", T, 1'b0);
                    checkOutput("rand_rst_BUSY", BUSY, 1'b0);
                    RST = 1'b1;
                end
                waitNeg(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
